// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, two-state data-memory handshake FSM and WB output steering.
// Optional request timeout with a sticky error flag is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        regWrite_in,
  input  logic [1:0]  memtoReg_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] writeData_in,
  input  logic [4:0]  writeReg_in,
  input  logic [31:0] PC_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  memtoReg_out,
  output logic        regWrite_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] readData_out,
  output logic [31:0] PC_out,
  output logic [4:0]  writeReg_out,
  output logic        dmem_err_out
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic        r_valid;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_reg_write;
  logic [1:0]  r_memto_reg;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [4:0]  r_wreg;
  logic [31:0] r_pc;

  logic in_req;
  logic wait_mem;
  logic timeout_abort;
  logic load_en;
  logic load_valid;
  logic next_is_mem;

  assign in_req      = (state == REQ);
  assign wait_mem    = in_req && !dmem_ready;
  assign stall_out   = wait_mem && !timeout_abort;
  assign load_en     = !stall_out;
  assign load_valid  = valid_in && !flush_in;
  assign next_is_mem = load_valid && (memRead_in || memWrite_in);

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  assign timeout_abort = wait_mem && (tmo_cnt == 4'd15);
  assign dmem_err_out  = err_q;

  // Counter restarts whenever R reloads (which covers every REQ entry) and counts unanswered cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      if (load_en)
        tmo_cnt <= 4'd0;
      else
        tmo_cnt <= tmo_cnt + 4'd1;
      if (timeout_abort)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_abort = 1'b0;
  assign dmem_err_out  = 1'b0;
`endif

  // Flushed or invalid inputs load as a bubble; data fields still follow the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_memto_reg <= 2'd0;
      r_alu       <= 32'd0;
      r_wdata     <= 32'd0;
      r_wreg      <= 5'd0;
      r_pc        <= 32'd0;
    end else if (load_en) begin
      r_valid     <= load_valid;
      r_mem_read  <= load_valid && memRead_in;
      r_mem_write <= load_valid && memWrite_in;
      r_reg_write <= load_valid && regWrite_in;
      r_memto_reg <= load_valid ? memtoReg_in : 2'd0;
      r_alu       <= ALUResult_in;
      r_wdata     <= writeData_in;
      r_wreg      <= writeReg_in;
      r_pc        <= PC_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (load_en)
      state <= next_is_mem ? REQ : IDLE;
  end

  assign dmem_req   = in_req;
  assign dmem_we    = in_req && r_mem_write;
  assign dmem_addr  = in_req ? r_alu : 32'd0;
  assign dmem_wdata = in_req ? r_wdata : 32'd0;

  // While memory has not answered, WB sees a bubble; the abort cycle is a bubble too.
  assign regWrite_out  = !wait_mem && r_valid && r_reg_write;
  assign memtoReg_out  = wait_mem ? 2'd0 : r_memto_reg;
  assign readData_out  = (in_req && dmem_ready && r_mem_read) ? dmem_rdata : 32'd0;
  assign ALUResult_out = r_alu;
  assign writeReg_out  = r_wreg;
  assign PC_out        = r_pc;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected WB results, a monitor checks retirements.
// Timeout checks follow MEM_STAGE_TIMEOUT_EN.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        flush_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic        regWrite_in;
  logic [1:0]  memtoReg_in;
  logic [31:0] ALUResult_in;
  logic [31:0] writeData_in;
  logic [4:0]  writeReg_in;
  logic [31:0] PC_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [1:0]  memtoReg_out;
  logic        regWrite_out;
  logic [31:0] ALUResult_out;
  logic [31:0] readData_out;
  logic [31:0] PC_out;
  logic [4:0]  writeReg_out;
  logic        dmem_err_out;

  typedef struct {
    logic        regWrite;
    logic [1:0]  memtoReg;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  wreg;
    logic [31:0] pc;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t expQ[$];
  int   numChecks = 0;
  int   numFails  = 0;
  int   stallCount;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .flush_in(flush_in),
    .memRead_in(memRead_in), .memWrite_in(memWrite_in), .regWrite_in(regWrite_in),
    .memtoReg_in(memtoReg_in), .ALUResult_in(ALUResult_in), .writeData_in(writeData_in),
    .writeReg_in(writeReg_in), .PC_in(PC_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .memtoReg_out(memtoReg_out), .regWrite_out(regWrite_out),
    .ALUResult_out(ALUResult_out), .readData_out(readData_out), .PC_out(PC_out),
    .writeReg_out(writeReg_out), .dmem_err_out(dmem_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic fl, input logic rd, input logic wr,
                               input logic rw, input logic [1:0] m2r, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] wreg, input logic [31:0] pc);
    valid_in     = v;
    flush_in     = fl;
    memRead_in   = rd;
    memWrite_in  = wr;
    regWrite_in  = rw;
    memtoReg_in  = m2r;
    ALUResult_in = alu;
    writeData_in = wd;
    writeReg_in  = wreg;
    PC_in        = pc;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic pushExp(input logic rw, input logic [1:0] m2r, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] wreg, input logic [31:0] pc,
                         input logic we, input logic [31:0] wdata);
    exp_t e;
    e.regWrite = rw;  e.memtoReg = m2r; e.alu = alu; e.rdata = rdata;
    e.wreg     = wreg; e.pc      = pc;  e.we  = we;  e.wdata = wdata;
    expQ.push_back(e);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stall_out"}, {31'd0, stall_out}, 32'd0);
    checkOutput({tag, " dmem_req"}, {31'd0, dmem_req}, 32'd0);
    checkOutput({tag, " dmem_we"}, {31'd0, dmem_we}, 32'd0);
    checkOutput({tag, " dmem_addr"}, dmem_addr, 32'd0);
    checkOutput({tag, " regWrite_out"}, {31'd0, regWrite_out}, 32'd0);
    checkOutput({tag, " memtoReg_out"}, {30'd0, memtoReg_out}, 32'd0);
    checkOutput({tag, " ALUResult_out"}, ALUResult_out, 32'd0);
    checkOutput({tag, " readData_out"}, readData_out, 32'd0);
    checkOutput({tag, " PC_out"}, PC_out, 32'd0);
    checkOutput({tag, " writeReg_out"}, {27'd0, writeReg_out}, 32'd0);
    checkOutput({tag, " dmem_err_out"}, {31'd0, dmem_err_out}, 32'd0);
  endtask

  // Monitor: a retirement is a non-stalled cycle that writes a register or completes a memory access.
  always @(negedge clk) begin
    if (!rst && !stall_out && (regWrite_out || (dmem_req && dmem_ready))) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected retirement PC", PC_out, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("wb regWrite_out", {31'd0, regWrite_out}, {31'd0, e.regWrite});
        checkOutput("wb memtoReg_out", {30'd0, memtoReg_out}, {30'd0, e.memtoReg});
        checkOutput("wb ALUResult_out", ALUResult_out, e.alu);
        checkOutput("wb readData_out", readData_out, e.rdata);
        checkOutput("wb writeReg_out", {27'd0, writeReg_out}, {27'd0, e.wreg});
        checkOutput("wb PC_out", PC_out, e.pc);
        checkOutput("wb dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
        if (e.we)
          checkOutput("wb dmem_wdata", dmem_wdata, e.wdata);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    applyIdle();
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    stepCycle();

    $display("[TB] ALU op");
    applyStimulus(1, 0, 0, 0, 1, 2'd0, 32'h10, 32'd0, 5'd3, 32'h100);
    pushExp(1, 2'd0, 32'h10, 32'd0, 5'd3, 32'h100, 0, 32'd0);
    stepCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("alu stall_out", {31'd0, stall_out}, 32'd0);
    checkOutput("alu dmem_req", {31'd0, dmem_req}, 32'd0);

    $display("[TB] load with two wait cycles");
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'h40, 32'd0, 5'd5, 32'h104);
    pushExp(1, 2'd1, 32'h40, 32'hDEADBEEF, 5'd5, 32'h104, 0, 32'd0);
    stepCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("load w1 stall_out", {31'd0, stall_out}, 32'd1);
    checkOutput("load w1 dmem_addr", dmem_addr, 32'h40);
    checkOutput("load w1 dmem_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("load w1 regWrite_out", {31'd0, regWrite_out}, 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("load w2 stall_out", {31'd0, stall_out}, 32'd1);
    checkOutput("load w2 memtoReg_out", {30'd0, memtoReg_out}, 32'd0);
    stepCycle();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("load done stall_out", {31'd0, stall_out}, 32'd0);
    stepCycle();
    dmem_ready = 1'b0;

    $display("[TB] zero-wait store");
    dmem_ready = 1'b1;
    dmem_rdata = 32'hAAAA_5555;
    applyStimulus(1, 0, 0, 1, 0, 2'd0, 32'h8, 32'h55, 5'd0, 32'h108);
    pushExp(0, 2'd0, 32'h8, 32'd0, 5'd0, 32'h108, 1, 32'h55);
    stepCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("store stall_out", {31'd0, stall_out}, 32'd0);
    checkOutput("store dmem_addr", dmem_addr, 32'h8);

    $display("[TB] back-to-back zero-wait loads");
    dmem_rdata = 32'h1234_5678;
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'h20, 32'd0, 5'd6, 32'h10C);
    pushExp(1, 2'd1, 32'h20, 32'h1234_5678, 5'd6, 32'h10C, 0, 32'd0);
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'h24, 32'd0, 5'd7, 32'h110);
    pushExp(1, 2'd1, 32'h24, 32'h1234_5678, 5'd7, 32'h110, 0, 32'd0);
    stepCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("b2b second dmem_addr", dmem_addr, 32'h24);
    stepCycle();
    dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("b2b after dmem_req", {31'd0, dmem_req}, 32'd0);

    $display("[TB] flushed load");
    applyStimulus(1, 1, 1, 0, 1, 2'd1, 32'h60, 32'd0, 5'd8, 32'h114);
    stepCycle();
    applyIdle();
    @(negedge clk);
    checkOutput("flush dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("flush regWrite_out", {31'd0, regWrite_out}, 32'd0);

    $display("[TB] flush ignored during stall");
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'h80, 32'd0, 5'd9, 32'h120);
    pushExp(1, 2'd1, 32'h80, 32'hCAFEF00D, 5'd9, 32'h120, 0, 32'd0);
    stepCycle();
    applyStimulus(1, 1, 1, 0, 1, 2'd1, 32'h90, 32'd0, 5'd10, 32'h200);
    @(negedge clk);
    checkOutput("stallflush w1 stall_out", {31'd0, stall_out}, 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("stallflush w2 PC_out", PC_out, 32'h120);
    checkOutput("stallflush w2 dmem_addr", dmem_addr, 32'h80);
    stepCycle();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    stepCycle();
    applyIdle();
    dmem_ready = 1'b0;
    @(negedge clk);
    checkOutput("stallflush after dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("stallflush after regWrite_out", {31'd0, regWrite_out}, 32'd0);

    $display("[TB] reset in first REQ cycle");
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'hA0, 32'd0, 5'd11, 32'h130);
    stepCycle();
    applyIdle();
    checkOutput("prereset dmem_req", {31'd0, dmem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    @(negedge clk);
    checkOutput("postreset dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("postreset stall_out", {31'd0, stall_out}, 32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    $display("[TB] timeout abort");
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'hB0, 32'd0, 5'd12, 32'h140);
    stepCycle();
    applyIdle();
    stallCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_out) break;
      stallCount++;
    end
    checkOutput("timeout stall cycles", stallCount, 32'd15);
    checkOutput("timeout abort regWrite_out", {31'd0, regWrite_out}, 32'd0);
    checkOutput("timeout abort dmem_err_out", {31'd0, dmem_err_out}, 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("timeout err set", {31'd0, dmem_err_out}, 32'd1);
    checkOutput("timeout dmem_req", {31'd0, dmem_req}, 32'd0);
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("timeout err held", {31'd0, dmem_err_out}, 32'd1);
`else
    $display("[TB] no timeout: request waits");
    stepCycle();
    applyStimulus(1, 0, 1, 0, 1, 2'd1, 32'hB0, 32'd0, 5'd12, 32'h140);
    stepCycle();
    applyIdle();
    stallCount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall_out) stallCount++;
    end
    checkOutput("notimeout stall cycles", stallCount, 32'd20);
    checkOutput("notimeout dmem_err_out", {31'd0, dmem_err_out}, 32'd0);
`endif

    rst = 1'b1;
    #2;
    checkOutput("final reset dmem_err_out", {31'd0, dmem_err_out}, 32'd0);
    checkOutput("final reset stall_out", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) stepCycle();
    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports, with clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX result valid.
- flush_in  in  1  squash the incoming EX result.
- memRead_in, memWrite_in, regWrite_in  in  1 each  control.
- memtoReg_in  in  2  writeback select.
- ALUResult_in  in  32  ALU result / data address.
- writeData_in  in  32  store data.
- writeReg_in  in  5  destination register.
- PC_in  in  32  instruction PC.
- stall_out  out  1  hold EX/IF/ID.
- dmem_req, dmem_we  out  1 each  memory request and write enable.
- dmem_addr, dmem_wdata  out  32 each  memory address and write data.
- dmem_ready  in  1  request completes this cycle.
- dmem_rdata  in  32  load data, valid with dmem_ready.
- memtoReg_out  out  2  to the WB register.
- regWrite_out  out  1  to the WB register.
- ALUResult_out, readData_out, PC_out  out  32 each  to the WB register.
- writeReg_out  out  5  to the WB register.
- dmem_err_out  out  1  sticky timeout error.

REQ-002 SHALL use one clock domain and an asynchronous, active-high reset.

Function
REQ-003 SHALL hold an internal EX/MEM register R (valid, control fields, ALUResult, writeData, writeReg, PC) and a 2-state FSM: IDLE, REQ.
REQ-004 R loading:
- R SHALL load the *_in fields at each rising edge where stall_out=0.
- On such an edge with flush_in=1 or valid_in=0, R SHALL load a bubble: valid=0, all controls 0.
REQ-005 Any edge where R loads a valid entry with memRead|memWrite SHALL move the FSM to REQ; otherwise the FSM SHALL stay in or return to IDLE.
REQ-006 In REQ:
- dmem_req=1, dmem_we=R.memWrite, dmem_addr=R.ALUResult, dmem_wdata=R.writeData.
- In IDLE, dmem_req=0 and dmem_we=0.
REQ-007 stall_out SHALL equal (state==REQ && !dmem_ready), a combinational signal.
REQ-008 REQ with dmem_ready=1 is the completion cycle:
- Outputs present R, with readData_out=dmem_rdata for a load and 0 for a store.
- At the edge: FSM goes to IDLE, or back to REQ if the newly loaded R is a memory op.
REQ-009 During REQ with dmem_ready=0, regWrite_out SHALL be 0 and memtoReg_out SHALL be 0 (bubble to WB).
REQ-010 In IDLE:
- Outputs SHALL mirror R, with regWrite_out = R.valid & R.regWrite.
- readData_out SHALL be 0.
REQ-011 ALUResult_out, writeReg_out and PC_out SHALL always mirror R unmodified.
REQ-012 flush_in SHALL be ignored while stall_out=1; the older instruction in R is never squashed.
REQ-013 Zero-wait memory (dmem_ready=1 in the first REQ cycle) SHALL give a one-cycle pass-through with no stall.

Reset
REQ-014 rst=1 SHALL immediately:
- Clear R to a bubble (all fields 0).
- Set the FSM to IDLE and clear the timeout counter and dmem_err_out.
- Drive every output to 0, including stall_out and dmem_req.
REQ-015 Reset asserted mid-REQ SHALL abandon the request; dmem_req drops asynchronously.

Configuration
REQ-016 Macro MEM_STAGE_TIMEOUT_EN:
- Defined:
  - A 4-bit counter SHALL clear on REQ entry and increment each REQ cycle with dmem_ready=0.
  - In the REQ cycle where the counter equals 15 and dmem_ready=0, the stage SHALL abort: stall_out=0 and regWrite_out=0 that cycle.
  - At that edge: FSM to IDLE and dmem_err_out set to 1, held until reset.
- Undefined: no counter; REQ waits indefinitely; dmem_err_out tied to 0.

Verification
REQ-017 ALU op: valid_in=1, regWrite_in=1, ALUResult_in=0x10, writeReg_in=3 -> next cycle regWrite_out=1, ALUResult_out=0x10, writeReg_out=3, stall_out=0, dmem_req=0.
REQ-018 Load, 2-cycle memory: memRead_in=1, ALUResult_in=0x40; dmem_ready low 2 cycles, then high with rdata=0xDEADBEEF -> dmem_addr=0x40; stall_out=1 for 2 cycles; completion cycle readData_out=0xDEADBEEF, regWrite_out=1.
REQ-019 Store, zero-wait: memWrite_in=1, writeData_in=0x55, ALUResult_in=0x8, dmem_ready=1 -> one cycle with dmem_we=1, dmem_wdata=0x55, stall_out=0, readData_out=0.
REQ-020 Flush: flush_in=1 with a valid load input -> R holds a bubble, dmem_req=0, regWrite_out=0; flush_in=1 during REQ stall -> ignored, load completes.
REQ-021 Reset: rst asserted in REQ cycle 1 -> same cycle dmem_req=0, stall_out=0, all outputs 0; after release, FSM is IDLE.
REQ-022 With MEM_STAGE_TIMEOUT_EN: load with dmem_ready held 0 -> stall_out=1 for 15 cycles, 16th cycle stall_out=0 and regWrite_out=0, then dmem_err_out=1 until reset.
